interp_line_feeder: RTL and testbench

INTERP_LINE_FEEDER -- requirements
Module: interp_line_feeder

---
 rtl/interp_line_feeder.sv | 125 ++++++++++++
 tb/tb_interp_line_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/interp_line_feeder.sv
// Frame-memory line feeder: streams edge-padded rows or columns of a stored
// frame into an interpolator and produces the capture strobe and destination index.
module interp_line_feeder #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 16,
    parameter int PRE_PAD  = 7,
    parameter int POST_PAD = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       start,
    input  logic       mode,
    output logic       busy,
    output logic       done,
    output logic [7:0] pix_out,
    output logic       pix_valid,
    output logic       cap_valid,
    output logic [7:0] cap_addr
);

    localparam int L     = PRE_PAD + WIDTH + POST_PAD;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int KW    = $clog2(L + 1);
    localparam int IW    = $clog2(HEIGHT + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [KW-1:0] K_LAST  = KW'(L - 1);
    localparam logic [KW-1:0] K_PRE   = KW'(PRE_PAD);
    localparam logic [KW-1:0] K_EDGE  = KW'(PRE_PAD + WIDTH);
    localparam logic [KW-1:0] K_CAP   = KW'(PRE_PAD + POST_PAD);
    localparam logic [IW-1:0] I_LAST  = IW'(HEIGHT - 1);
    localparam logic [AW-1:0] A_WIDTH = AW'(WIDTH);
    localparam logic [AW-1:0] A_CMAX  = AW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [IW-1:0] i;
    logic          mode_q;
    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] c_a;
    logic [AW-1:0] i_a;
    logic [AW-1:0] j_a;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] cap_calc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            i      <= '0;
            k      <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= STREAM;
                        mode_q <= mode;
                        i      <= '0;
                        k      <= '0;
                    end
                end
                STREAM: begin
                    if (k == K_LAST) begin
                        k <= '0;
                        if (i == I_LAST) begin
                            state <= DONE;
                            i     <= '0;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately outside reset so a frame survives an aborted pass.
    always_ff @(posedge clock) begin
        if (state == IDLE && load_en && 32'(load_addr) < DEPTH) begin
            mem[AW'(load_addr)] <= load_data;
        end
    end

    // Clamping the sample index replicates the edge pixels into the pads.
    always_comb begin
        if (k < K_PRE) begin
            c_a = '0;
        end else if (k >= K_EDGE) begin
            c_a = A_CMAX;
        end else begin
            c_a = AW'(k - K_PRE);
        end
        i_a      = AW'(i);
        j_a      = AW'(k - K_CAP);
        rd_addr  = mode_q ? (c_a * A_WIDTH + i_a) : (i_a * A_WIDTH + c_a);
        cap_calc = mode_q ? (i_a + A_WIDTH * j_a) : (i_a * A_WIDTH + j_a);

        busy      = 1'b0;
        done      = (state == DONE);
        pix_valid = 1'b0;
        pix_out   = 8'd0;
        cap_valid = 1'b0;
        cap_addr  = 8'd0;
        if (state == STREAM) begin
            busy      = 1'b1;
            pix_valid = 1'b1;
            pix_out   = mem[rd_addr];
            if (k >= K_CAP) begin
                cap_valid = 1'b1;
                cap_addr  = 8'(cap_calc);
            end
        end
    end

endmodule

// File: tb/tb_interp_line_feeder.sv
// Randomized bench for interp_line_feeder: a frame/pass-level reference model
// checked every cycle, plus literal expectations for ramp frames and corner cases.
module tb_interp_line_feeder;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int PRE  = 7;
    localparam int POST = 6;
    localparam int L    = PRE + W + POST;
    localparam int PASS = H * L;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'd0;
    logic [7:0] load_data = 8'd0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy, done, pix_valid, cap_valid;
    logic [7:0] pix_out, cap_addr;

    interp_line_feeder #(.WIDTH(W), .HEIGHT(H), .PRE_PAD(PRE), .POST_PAD(POST)) dut (
        .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .mode(mode), .busy(busy), .done(done),
        .pix_out(pix_out), .pix_valid(pix_valid), .cap_valid(cap_valid), .cap_addr(cap_addr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a pass is just a count n of stream cycles since start.
    logic [7:0] m_mem [W*H];
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    bit         m_mode = 1'b0;
    int         m_n = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_n      <= 0;
            m_mode   <= 1'b0;
        end else if (m_active) begin
            if (m_n == PASS - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_n <= m_n + 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else begin
            if (load_en) m_mem[load_addr] <= load_data;
            if (start) begin
                m_active <= 1'b1;
                m_n      <= 0;
                m_mode   <= mode;
            end
        end
    end

    always @(negedge clock) begin
        int mi, mk, mc, mj;
        logic [7:0] e_pix, e_addr;
        logic e_cap;
        if (cmp_on) begin
            e_pix = 8'd0; e_cap = 1'b0; e_addr = 8'd0;
            if (m_active) begin
                mi = m_n / L;
                mk = m_n % L;
                mc = (mk < PRE) ? 0 : ((mk - PRE >= W) ? W - 1 : mk - PRE);
                e_pix = m_mode ? m_mem[mc*W + mi] : m_mem[mi*W + mc];
                if (mk >= PRE + POST) begin
                    mj = mk - PRE - POST;
                    e_cap = 1'b1;
                    e_addr = 8'(m_mode ? (mi + W*mj) : (mi*W + mj));
                end
            end
            checkOutput("busy", busy, m_active);
            checkOutput("done", done, m_done);
            checkOutput("pix_valid", pix_valid, m_active);
            checkOutput("pix_out", pix_out, e_pix);
            checkOutput("cap_valid", cap_valid, e_cap);
            checkOutput("cap_addr", cap_addr, e_addr);
        end
    end

    logic [7:0] rec_pix [PASS];
    logic [7:0] rec_addr [PASS];
    bit         rec_cap [PASS];
    int         nb;
    int         done_t;

    task automatic applyStimulus(input bit st, input bit md, input bit ld, input logic [7:0] a, input logic [7:0] d);
        start = st; mode = md; load_en = ld; load_addr = a; load_data = d;
        @(negedge clock);
        start = 1'b0; load_en = 1'b0;
    endtask

    task automatic runPass(input bit md, input bit inject, input bit ld, input logic [7:0] la, input logic [7:0] ldat);
        start = 1'b1; mode = md; load_en = ld; load_addr = la; load_data = ldat;
        @(negedge clock);
        start = 1'b0; load_en = 1'b0; mode = 1'($urandom_range(0, 1));
        nb = 0; done_t = -1;
        for (int t = 0; t < PASS + 20; t++) begin
            if (busy === 1'b1 && nb < PASS) begin
                rec_pix[nb] = pix_out; rec_cap[nb] = cap_valid; rec_addr[nb] = cap_addr;
                nb++;
            end
            if (done === 1'b1) begin
                done_t = t;
                break;
            end
            if (inject && t >= 50 && t < 53) begin
                start = 1'b1; load_en = 1'b1; load_addr = 8'd40; load_data = 8'd99;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0; load_en = 1'b0;
        checkOutput("pass_len", nb, PASS);
        checkOutput("done_cycle", done_t, PASS);
        @(negedge clock);
        checkOutput("idle_after_done", {busy, done}, 0);
    endtask

    initial begin
        bit seen [256];
        int ncap, nuniq;

        @(negedge clock);
        cmp_on = 1'b1;
        checkOutput("reset_outputs", {busy, done, pix_valid, cap_valid, pix_out, cap_addr}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int a = 0; a < 256; a++) applyStimulus(0, 0, 1, 8'(a), 8'(a));

        // Ramp frame, row pass: line 0 edge padding and capture window.
        runPass(0, 0, 0, 0, 0);
        checkOutput("row_k0", rec_pix[0], 0);
        checkOutput("row_k6", rec_pix[6], 0);
        checkOutput("row_k7", rec_pix[7], 0);
        checkOutput("row_k8", rec_pix[8], 1);
        checkOutput("row_k22", rec_pix[22], 15);
        checkOutput("row_k23", rec_pix[23], 15);
        checkOutput("row_k28", rec_pix[28], 15);
        checkOutput("row_cap_k12", rec_cap[12], 0);
        checkOutput("row_cap_k13", rec_cap[13], 1);
        checkOutput("row_addr_k13", rec_addr[13], 0);
        checkOutput("row_addr_k28", rec_addr[28], 15);

        // Column pass, line 3 starts at stream cycle 87.
        runPass(1, 0, 0, 0, 0);
        checkOutput("col_k7", rec_pix[94], 3);
        checkOutput("col_k8", rec_pix[95], 19);
        checkOutput("col_k22", rec_pix[109], 243);
        checkOutput("col_k28", rec_pix[115], 243);
        checkOutput("col_addr_k13", rec_addr[100], 3);
        checkOutput("col_addr_k14", rec_addr[101], 19);
        checkOutput("col_addr_k28", rec_addr[115], 243);
        ncap = 0; nuniq = 0;
        foreach (seen[x]) seen[x] = 1'b0;
        for (int n = 0; n < PASS; n++) begin
            if (rec_cap[n]) begin
                ncap++;
                if (!seen[rec_addr[n]]) nuniq++;
                seen[rec_addr[n]] = 1'b1;
            end
        end
        checkOutput("cap_count", ncap, 256);
        checkOutput("cap_unique", nuniq, 256);

        // Start and load mid-pass are ignored; mem[40] sits at line 2, k=15.
        runPass(0, 1, 0, 0, 0);
        runPass(0, 0, 0, 0, 0);
        checkOutput("mem40_kept", rec_pix[2*L + 15], 40);

        // Reset at line 2, k=10 aborts the pass without a done pulse.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (2*L + 10) @(negedge clock);
        checkOutput("pre_reset_pix", pix_out, 35);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("abort_outputs", {busy, done, pix_valid, cap_valid, pix_out, cap_addr}, 0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            checkOutput("abort_no_done", done, 0);
        end
        runPass(0, 0, 0, 0, 0);
        checkOutput("restart_k8", rec_pix[8], 1);
        checkOutput("restart_addr_k13", rec_addr[13], 0);

        // Load and start in the same idle cycle.
        runPass(0, 0, 1, 8'd0, 8'd200);
        checkOutput("same_cycle_first_pix", rec_pix[0], 200);
        checkOutput("same_cycle_k7", rec_pix[7], 200);

        // Random frames, modes and idle traffic against the model.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 256; a++) begin
                applyStimulus(0, 0, 1, 8'(a), 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0) @(negedge clock);
            end
            runPass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
